cgra_conf_loader: RTL

CGRA_CONF_LOADER -- requirements
Module: cgra_conf_loader

---
 rtl/cgra_pkg.sv | 24 ++
 rtl/cgra_conf_loader.sv | 133 +++++++++++++
 2 files changed

// File: rtl/cgra_pkg.sv
// Shared CGRA configuration constants and the kernel loader's state type.
package cgra_pkg;

    localparam int unsigned INSTR_WIDTH       = 32;
    localparam int unsigned RCS_NUM_CREG      = 32;
    localparam int unsigned RCS_NUM_CREG_LOG2 = 5;

    typedef enum logic [1:0] {
        LDR_IDLE = 2'd0,
        LDR_LOAD = 2'd1,
        LDR_DONE = 2'd2
    } ldr_state_e;

    // Longer requests cannot address more than RCS_NUM_CREG registers per cell.
    function automatic logic [RCS_NUM_CREG_LOG2:0] ldr_clamp_len(
        input logic [RCS_NUM_CREG_LOG2:0] len
    );
        if (len > (RCS_NUM_CREG_LOG2 + 1)'(RCS_NUM_CREG)) begin
            return (RCS_NUM_CREG_LOG2 + 1)'(RCS_NUM_CREG);
        end
        return len;
    endfunction

endpackage

// File: rtl/cgra_conf_loader.sv
// Streams a kernel's instruction words into the per-cell configuration register
// files, cell-inner / pc-outer, with one registered write per accepted word.
module cgra_conf_loader
    import cgra_pkg::*;
#(
    parameter int unsigned N_RC = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic [RCS_NUM_CREG_LOG2:0]     len_i,
    input  logic                           abort_i,
    input  logic                           data_valid_i,
    input  logic [INSTR_WIDTH-1:0]         data_i,
    output logic                           data_ready_o,
    output logic [INSTR_WIDTH-1:0]         instr_o,
    output logic [RCS_NUM_CREG_LOG2-1:0]   pc_o,
    output logic [N_RC-1:0]                we_o,
    output logic                           busy_o,
    output logic                           done_o
);

    localparam int unsigned RC_W  = (N_RC > 1) ? $clog2(N_RC) : 1;
    localparam int unsigned PC_W  = RCS_NUM_CREG_LOG2;
    localparam int unsigned LEN_W = RCS_NUM_CREG_LOG2 + 1;

    ldr_state_e             state_q, state_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [PC_W-1:0]        pc_cnt_q, pc_cnt_d;
    logic [RC_W-1:0]        rc_cnt_q, rc_cnt_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [PC_W-1:0]        pc_q, pc_d;
    logic [N_RC-1:0]        we_q, we_d;
    logic                   done_q, done_d;

    logic [N_RC-1:0]        rc_onehot;
    logic                   rc_last;
    logic                   pc_last;

    always_comb begin
        rc_onehot = '0;
        for (int unsigned i = 0; i < N_RC; i++) begin
            rc_onehot[i] = (rc_cnt_q == RC_W'(i));
        end
    end

    assign rc_last = (rc_cnt_q == RC_W'(N_RC - 1));
    assign pc_last = ({1'b0, pc_cnt_q} == (len_q - LEN_W'(1)));

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        pc_cnt_d = pc_cnt_q;
        rc_cnt_d = rc_cnt_q;
        instr_d  = instr_q;
        pc_d     = pc_q;
        we_d     = '0;
        done_d   = 1'b0;

        unique case (state_q)
            LDR_IDLE: begin
                if (start_i) begin
                    if (len_i == '0) begin
                        state_d = LDR_DONE;
                        done_d  = 1'b1;
                    end else begin
                        len_d    = ldr_clamp_len(len_i);
                        pc_cnt_d = '0;
                        rc_cnt_d = '0;
                        state_d  = LDR_LOAD;
                    end
                end
            end
            LDR_LOAD: begin
                // Abort wins over a coincident handshake: the word is dropped.
                if (abort_i) begin
                    state_d = LDR_IDLE;
                end else if (data_valid_i) begin
                    instr_d = data_i;
                    pc_d    = pc_cnt_q;
                    we_d    = rc_onehot;
                    if (rc_last) begin
                        rc_cnt_d = '0;
                        if (pc_last) begin
                            state_d = LDR_DONE;
                            done_d  = 1'b1;
                        end else begin
                            pc_cnt_d = pc_cnt_q + PC_W'(1);
                        end
                    end else begin
                        rc_cnt_d = rc_cnt_q + RC_W'(1);
                    end
                end
            end
            LDR_DONE: begin
                state_d = LDR_IDLE;
            end
            default: begin
                state_d = LDR_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= LDR_IDLE;
            len_q    <= '0;
            pc_cnt_q <= '0;
            rc_cnt_q <= '0;
            instr_q  <= '0;
            pc_q     <= '0;
            we_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            pc_cnt_q <= pc_cnt_d;
            rc_cnt_q <= rc_cnt_d;
            instr_q  <= instr_d;
            pc_q     <= pc_d;
            we_q     <= we_d;
            done_q   <= done_d;
        end
    end

    assign data_ready_o = (state_q == LDR_LOAD);
    assign busy_o       = (state_q != LDR_IDLE);
    assign done_o       = done_q;
    assign instr_o      = instr_q;
    assign pc_o         = pc_q;
    assign we_o         = we_q;

endmodule
